// File: rtl/mem_resp_queue_if.sv
// Execute / data-bus / writeback bundle for mem_resp_queue.
// The master modport is the pipeline environment (execute stage, data bus,
// writeback). The slave modport is the completion unit.
interface mem_resp_queue_if #(
    parameter int DEST_W = 5
);
    // execute -> queue
    logic              in_valid;
    logic              in_ready;
    logic              in_is_load;
    logic              in_is_store;
    logic [1:0]        in_size;
    logic              in_sign;
    logic              in_lwl;
    logic              in_lwr;
    logic [1:0]        in_addr_lo;
    logic [31:0]       in_rt_value;
    logic [31:0]       in_alu_result;
    logic              in_gr_we;
    logic [DEST_W-1:0] in_dest;
    logic [31:0]       in_pc;
    // data bus responses
    logic              data_ok;
    logic [31:0]       rdata;
    // queue -> writeback
    logic              out_valid;
    logic              out_ready;
    logic              out_gr_we;
    logic [DEST_W-1:0] out_dest;
    logic [31:0]       out_result;
    logic [31:0]       out_pc;

    modport master (
        output in_valid, in_is_load, in_is_store, in_size, in_sign, in_lwl, in_lwr,
               in_addr_lo, in_rt_value, in_alu_result, in_gr_we, in_dest, in_pc,
        input  in_ready,
        output data_ok, rdata,
        input  out_valid, out_gr_we, out_dest, out_result, out_pc,
        output out_ready
    );

    modport slave (
        input  in_valid, in_is_load, in_is_store, in_size, in_sign, in_lwl, in_lwr,
               in_addr_lo, in_rt_value, in_alu_result, in_gr_we, in_dest, in_pc,
        output in_ready,
        input  data_ok, rdata,
        output out_valid, out_gr_we, out_dest, out_result, out_pc,
        input  out_ready
    );
endinterface

// File: rtl/mem_resp_queue.sv
// Memory-stage completion queue for the in-order pipeline.
// Holds up to DEPTH instructions, matches in-order data_ok responses to the
// oldest pending load/store, formats load data on capture and retires in
// program order. On flush, responses still owed for dropped requests are
// counted in cancel_q and swallowed when they arrive.
// Optional feature macro: UNALIGNED_LOAD_EN (honour LWL/LWR merges).
module mem_resp_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int DEST_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    mem_resp_queue_if.slave  bus,
    output logic [PTR_W:0]   occupancy,
    output logic             cancel_pending
);

    typedef struct packed {
        logic              mem;
        logic              load;
        logic              done;
        logic [31:0]       result;
        logic              gr_we;
        logic [DEST_W-1:0] dest;
        logic [31:0]       pc;
        logic [1:0]        size;
        logic              sign;
        logic [1:0]        addr_lo;
`ifdef UNALIGNED_LOAD_EN
        logic              lwl;
        logic              lwr;
        logic [31:0]       rt;
`endif
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   cancel_q, cancel_d;

    logic             resp_found;
    logic [PTR_W-1:0] resp_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W:0]   outstanding;
    logic             in_ready_w;
    logic             push;
    logic             pop;
    logic             out_valid_w;
    logic             resp_sub;

`ifndef UNALIGNED_LOAD_EN
    // Unaligned-load inputs have no effect in this build.
    logic unused_unaligned;
    assign unused_unaligned = ^{bus.in_lwl, bus.in_lwr, bus.in_rt_value};
`endif

    // Extract and extend the addressed bytes of a read response for one entry.
    function automatic logic [31:0] fmt_load(entry_t e, logic [31:0] rd);
        logic [4:0]  bsh;
        logic [31:0] sh8;
        logic [31:0] sh16;
        logic [31:0] res;
        bsh  = {e.addr_lo, 3'b000};
        sh8  = rd >> bsh;
        sh16 = rd >> {e.addr_lo[1], 4'b0000};
        case (e.size)
            2'd0:    res = {{24{e.sign & sh8[7]}}, sh8[7:0]};
            2'd1:    res = {{16{e.sign & sh16[15]}}, sh16[15:0]};
            default: res = rd;
        endcase
`ifdef UNALIGNED_LOAD_EN
        // LWL keeps the low 24-8k bits of rt; LWR keeps the high 8k bits.
        if (e.lwl)
            res = (rd << (5'd24 - bsh)) | (e.rt & (32'h00FF_FFFF >> bsh));
        else if (e.lwr)
            res = (rd >> bsh) | (e.rt & ~(32'hFFFF_FFFF >> bsh));
`endif
        return res;
    endfunction

    // Find the oldest live memory entry still waiting and count all waiting ones.
    always_comb begin
        resp_found  = 1'b0;
        resp_idx    = '0;
        scan_idx    = '0;
        outstanding = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && ent_q[scan_idx].mem && !ent_q[scan_idx].done) begin
                outstanding = outstanding + 1'b1;
                if (!resp_found) begin
                    resp_found = 1'b1;
                    resp_idx   = scan_idx;
                end
            end
        end
    end

    // Handshake qualifiers; cancelled responses still occupy capacity.
    always_comb begin
        in_ready_w  = !reset && !flush &&
                      (({1'b0, count_q} + {1'b0, cancel_q}) < (PTR_W+2)'(DEPTH));
        out_valid_w = (count_q != '0) && ent_q[head_q].done;
        push        = bus.in_valid && in_ready_w;
        pop         = out_valid_w && bus.out_ready && !flush;
        resp_sub    = bus.data_ok && ((cancel_q != '0) || (outstanding != '0));
    end

    // Next-state: response capture, pop, push, then flush override.
    always_comb begin
        ent_d    = ent_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        cancel_d = cancel_q;

        if (bus.data_ok) begin
            if (cancel_q != '0) begin
                cancel_d = cancel_q - 1'b1;
            end else if (resp_found) begin
                ent_d[resp_idx].done = 1'b1;
                if (ent_q[resp_idx].load)
                    ent_d[resp_idx].result = fmt_load(ent_q[resp_idx], bus.rdata);
                else
                    ent_d[resp_idx].gr_we = 1'b0;
            end
        end

        if (pop) begin
            head_d  = head_q + 1'b1;
            count_d = count_d - 1'b1;
        end

        if (push) begin
            ent_d[tail_q].mem     = bus.in_is_load || bus.in_is_store;
            ent_d[tail_q].load    = bus.in_is_load;
            ent_d[tail_q].done    = !(bus.in_is_load || bus.in_is_store);
            ent_d[tail_q].result  = bus.in_alu_result;
            ent_d[tail_q].gr_we   = bus.in_gr_we && !(bus.in_is_store && !bus.in_is_load);
            ent_d[tail_q].dest    = bus.in_dest;
            ent_d[tail_q].pc      = bus.in_pc;
            ent_d[tail_q].size    = bus.in_size;
            ent_d[tail_q].sign    = bus.in_sign;
            ent_d[tail_q].addr_lo = bus.in_addr_lo;
`ifdef UNALIGNED_LOAD_EN
            ent_d[tail_q].lwl     = bus.in_lwl;
            ent_d[tail_q].lwr     = bus.in_lwr;
            ent_d[tail_q].rt      = bus.in_rt_value;
`endif
            tail_d  = tail_q + 1'b1;
            count_d = count_d + 1'b1;
        end

        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            cancel_d = cancel_q + outstanding - {{PTR_W{1'b0}}, resp_sub};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cancel_q <= '0;
        end else begin
            ent_q    <= ent_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cancel_q <= cancel_d;
        end
    end

    // Outputs come straight from the head entry and live counters.
    always_comb begin
        bus.in_ready   = in_ready_w;
        bus.out_valid  = out_valid_w;
        bus.out_gr_we  = ent_q[head_q].gr_we;
        bus.out_dest   = ent_q[head_q].dest;
        bus.out_result = ent_q[head_q].result;
        bus.out_pc     = ent_q[head_q].pc;
        occupancy      = count_q;
        cancel_pending = (cancel_q != '0);
    end

    // A response with nothing owed and nothing to cancel is a bus protocol error.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
        bus.data_ok |-> ((cancel_q != '0) || resp_found));

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed self-checking bench for mem_resp_queue (DEPTH=4).
module tb_mem_resp_queue;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [2:0] occupancy;
    logic       cancel_pending;
    int         total;
    int         bad;

    mem_resp_queue_if #(.DEST_W(5)) bus ();

    mem_resp_queue #(.DEPTH(4), .DEST_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .bus            (bus),
        .occupancy      (occupancy),
        .cancel_pending (cancel_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_is_store   = 1'b0;
        bus.in_size       = 2'd2;
        bus.in_sign       = 1'b0;
        bus.in_lwl        = 1'b0;
        bus.in_lwr        = 1'b0;
        bus.in_addr_lo    = 2'd0;
        bus.in_rt_value   = 32'h0;
        bus.in_alu_result = 32'h0;
        bus.in_gr_we      = 1'b0;
        bus.in_dest       = 5'd0;
        bus.in_pc         = 32'h0;
        bus.data_ok       = 1'b0;
        bus.rdata         = 32'h0;
        bus.out_ready     = 1'b0;
        flush             = 1'b0;
    endtask

    // kind: 0 non-mem, 1 load, 2 store
    task automatic push(input int kind, input logic [1:0] size, input logic sign,
                        input logic lwl, input logic lwr, input logic [1:0] alo,
                        input logic [31:0] rt, input logic [31:0] alu,
                        input logic [4:0] dest, input logic [31:0] pc);
        int n;
        bus.in_is_load    = (kind == 1);
        bus.in_is_store   = (kind == 2);
        bus.in_size       = size;
        bus.in_sign       = sign;
        bus.in_lwl        = lwl;
        bus.in_lwr        = lwr;
        bus.in_addr_lo    = alo;
        bus.in_rt_value   = rt;
        bus.in_alu_result = alu;
        bus.in_gr_we      = 1'b1;
        bus.in_dest       = dest;
        bus.in_pc         = pc;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("push_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] rd);
        bus.data_ok = 1'b1;
        bus.rdata   = rd;
        tick();
        bus.data_ok = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic do_res, input logic [31:0] res,
                              input logic gr_we, input logic [4:0] dest);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        if (do_res) chk({tag, "_result"}, bus.out_result, res);
        chk({tag, "_gr_we"}, {31'b0, bus.out_gr_we}, {31'b0, gr_we});
        chk({tag, "_dest"}, {27'b0, bus.out_dest}, {27'b0, dest});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [1:0] size, input logic sign,
                             input logic lwl, input logic lwr, input logic [1:0] alo,
                             input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
        push(1, size, sign, lwl, lwr, alo, rt, 32'h0, 5'd9, 32'h200);
        chk({tag, "_wait"}, {31'b0, bus.out_valid}, 32'd0);
        resp(rd);
        chk({tag, "_lat"}, {31'b0, bus.out_valid}, 32'd1);
        pop_expect(tag, 1'b1, exp, 1'b1, 5'd9);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        tick();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_occ", {29'b0, occupancy}, 32'd0);
        chk("rst_cancel", {31'b0, cancel_pending}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // non-memory op: valid the cycle after push
        push(0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0000_1234, 5'd3, 32'h100);
        chk("nm_lat", {31'b0, bus.out_valid}, 32'd1);
        chk("nm_pc", bus.out_pc, 32'h100);
        pop_expect("nm", 1'b1, 32'h0000_1234, 1'b1, 5'd3);
        chk("nm_empty", {29'b0, occupancy}, 32'd0);

        // load formatting
        load_case("lb_s",  2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0080_0000, 32'hFFFF_FF80);
        load_case("lb_u",  2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0080_0000, 32'h0000_0080);
        load_case("lb_3",  2'd0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h0, 32'h7F00_0000, 32'h0000_007F);
        load_case("lh_s",  2'd1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h8001_0000, 32'hFFFF_8001);
        load_case("lh_u",  2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1234_ABCD, 32'h0000_ABCD);
        load_case("lw",    2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
`ifdef UNALIGNED_LOAD_EN
        load_case("lwl",   2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        load_case("lwr",   2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
`else
        load_case("lwl_w", 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
        load_case("lwr_w", 2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
`endif

        // fill to DEPTH with writeback stalled
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,     5'd1, 32'h300);
        push(0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h55,    5'd2, 32'h304);
        push(2, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,     5'd3, 32'h308);
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,     5'd4, 32'h30C);
        chk("full_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_occ", {29'b0, occupancy}, 32'd4);
        chk("full_wait", {31'b0, bus.out_valid}, 32'd0);
        resp(32'h1111_1111);
        resp(32'h2222_2222);
        chk("full_head_v", {31'b0, bus.out_valid}, 32'd1);
        chk("full_head_r", bus.out_result, 32'h1111_1111);
        // pop at full with a push offered: only the pop happens
        bus.in_is_load    = 1'b0;
        bus.in_is_store   = 1'b0;
        bus.in_alu_result = 32'h99;
        bus.in_valid      = 1'b1;
        bus.out_ready     = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("full_pop_occ", {29'b0, occupancy}, 32'd3);
        pop_expect("d_nm", 1'b1, 32'h55, 1'b1, 5'd2);
        pop_expect("d_st", 1'b0, 32'h0, 1'b0, 5'd3);
        chk("d_ld_wait", {31'b0, bus.out_valid}, 32'd0);
        resp(32'h3333_3333);
        pop_expect("d_ld", 1'b1, 32'h3333_3333, 1'b1, 5'd4);
        chk("d_empty", {29'b0, occupancy}, 32'd0);

        // flush with two loads outstanding
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd5, 32'h400);
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd6, 32'h404);
        flush = 1'b1;
        #1;
        chk("fl_block", {31'b0, bus.in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_occ", {29'b0, occupancy}, 32'd0);
        chk("fl_cancel", {31'b0, cancel_pending}, 32'd1);
        chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd7, 32'h408);
        resp(32'h0000_000A);
        chk("fl_c1", {31'b0, cancel_pending}, 32'd1);
        chk("fl_v1", {31'b0, bus.out_valid}, 32'd0);
        resp(32'h0000_000B);
        chk("fl_c2", {31'b0, cancel_pending}, 32'd0);
        chk("fl_v2", {31'b0, bus.out_valid}, 32'd0);
        resp(32'h0000_000C);
        pop_expect("fl_ld", 1'b1, 32'h0000_000C, 1'b1, 5'd7);

        // flush coincident with a response, three outstanding
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd8, 32'h500);
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd8, 32'h504);
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd8, 32'h508);
        flush       = 1'b1;
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h0000_00EE;
        tick();
        flush       = 1'b0;
        bus.data_ok = 1'b0;
        chk("fd_occ", {29'b0, occupancy}, 32'd0);
        chk("fd_c0", {31'b0, cancel_pending}, 32'd1);
        resp(32'h0000_00E1);
        chk("fd_c1", {31'b0, cancel_pending}, 32'd1);
        resp(32'h0000_00E2);
        chk("fd_c2", {31'b0, cancel_pending}, 32'd0);
        push(1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd10, 32'h600);
        resp(32'h0000_000D);
        pop_expect("fd_ld", 1'b1, 32'h0000_000D, 1'b1, 5'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_resp_queue.md
Name: mem_resp_queue

Overview:
Parametrised memory-stage completion unit for the in-order MIPS pipeline.
- Accepts up to DEPTH in-flight instructions from execute: loads, stores and non-memory ops.
- Matches in-order data_ok responses to outstanding loads/stores, formats load data, and retires results to writeback in program order.
- Handles flush by dropping queued entries and silently absorbing responses to cancelled requests.

Parameters:
DEPTH, 4, queue entries and maximum outstanding data requests (power of 2, >=2)
PTR_W, $clog2(DEPTH), pointer width (derived)
DEST_W, 5, register-destination width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  execute presents an instruction
in_ready  out  1  queue accepts (push = in_valid & in_ready)
in_is_load  in  1  instruction waits for a data_ok read response
in_is_store  in  1  instruction waits for a data_ok write ack
in_size  in  2  0 byte, 1 half, 2 word
in_sign  in  1  sign-extend byte/half load
in_lwl  in  1  LWL load
in_lwr  in  1  LWR load
in_addr_lo  in  2  address[1:0]
in_rt_value  in  32  old rt, used for LWL/LWR merge
in_alu_result  in  32  result for non-memory entries
in_gr_we  in  1  writes a GPR
in_dest  in  DEST_W  destination register
in_pc  in  32  instruction PC
data_ok  in  1  one in-order response/ack this cycle
rdata  in  32  read data, valid with data_ok
out_valid  out  1  head entry complete
out_ready  in  1  writeback accepts (pop = out_valid & out_ready)
out_gr_we  out  1  head writes a GPR; 0 for stores
out_dest  out  DEST_W  head destination
out_result  out  32  formatted load data or alu_result
out_pc  out  32  head PC
flush  in  1  exception/eret flush from writeback
occupancy  out  PTR_W+1  live entries
cancel_pending  out  1  cancel counter nonzero

Behaviour:
- Reset (synchronous) clears all entries, head/tail/resp pointers and cancel_cnt to 0.
  - Registered outputs are 0: out_valid=0, occupancy=0, cancel_pending=0.
  - in_ready is 0 while reset is high.
- Handshakes:
  - in_ready = !reset & !flush & (occupancy + cancel_cnt < DEPTH).
  - A push and a pop may occur in the same cycle.
  - Push is judged on pre-pop occupancy, so at full there is no push even if a pop occurs.
- Entry state: {mem, done, result, gr_we, dest, pc, fmt fields}.
  - A non-memory push sets done=1 and result=alu_result.
  - A memory push (in_is_load or in_is_store) sets done=0.
- Response matching:
  - If cancel_cnt>0, data_ok decrements cancel_cnt and is discarded.
  - Otherwise data_ok completes the entry at resp_ptr.
  - resp_ptr advances to the next memory entry; it skips non-memory entries, scanning from the oldest not-done memory entry.
  - Load data is formatted at capture and stored registered. A store sets done=1 with gr_we forced to 0.
  - data_ok with no outstanding request and cancel_cnt==0 is a protocol error. It is ignored, and the RTL carries an assertion.
- Latency:
  - A non-memory push in cycle t with the queue empty gives out_valid in t+1.
  - data_ok in cycle t for the head gives out_valid in t+1.
  - Throughput is 1 pop/cycle.
- Output: out_valid = head.done & occupancy!=0. Fields come from the head entry and are held stable until pop.
- Load formatting (k = addr_lo):
  - Byte: rdata[8k+7:8k], sign- or zero-extended per in_sign.
  - Half: rdata[16*addr_lo[1]+15 : 16*addr_lo[1]], extended.
  - Word: rdata unchanged.
- Flush:
  - Next cycle all entries are invalid, pointers reset, out_valid=0.
  - cancel_cnt <= cancel_cnt + outstanding_mem - (data_ok ? 1 : 0).
  - outstanding_mem counts not-done memory entries; the pre-flush cancel_cnt is included.
  - Push is blocked in the flush cycle.
  - A pop in the flush cycle is ignored by the unit; writeback owns the flush.
- Reset during any state, including cancel_cnt>0, wins over everything. The external bus is reset in the same cycle.

Optional Feature:
UNALIGNED_LOAD_EN:
- Defined: LWL/LWR are honoured.
  - LWL: {rdata[8k+7:0], rt[23-8k:0]}; k=3 gives rdata.
  - LWR: {rt[31:32-8k], rdata[31:8k]}; k=0 gives rdata.
  - in_rt_value is stored per entry.
- Undefined: in_lwl/in_lwr are ignored and treated as word loads; rt storage is not synthesised.

Test Plan:
- Non-memory push, alu_result=0x1234, empty queue -> out_valid next cycle, out_result=0x1234, out_gr_we=1.
- Byte load at addr_lo=2, sign=1, data_ok with rdata=0x00800000 -> out_result=0xFFFFFF80. Same load with sign=0 -> 0x00000080.
- Push DEPTH=4 entries (load, non-mem, store, load), out_ready=0:
  - in_ready=0 after the 4th push.
  - Two data_ok -> first load done, store done.
  - Drain in order: load, non-mem, store (gr_we=0). Last load retires after its data_ok.
- Two loads outstanding, flush -> cancel_cnt=2, cancel_pending=1, occupancy=0.
  - New load pushed.
  - Three data_ok (rdata 0xA, 0xB, 0xC) -> only 0xC retires.
- Flush coincident with data_ok, 3 outstanding -> cancel_cnt=2.
- With UNALIGNED_LOAD_EN: LWL addr_lo=1, rt=0x11223344, rdata=0xAABBCCDD -> 0xCCDD3344. LWR addr_lo=1 -> 0x11AABBCC.
